// File: rtl/and_vec_source.sv
// and_vec_source: pattern generator feeding the x input of the AND cascade.
// Produces a LENGTH-bit vector in one of four patterns (up, down, LFSR,
// walking-one) behind a valid/ready handshake. Supports seed loading, an
// optional beat limit and a one-cycle wrap pulse when the pattern returns
// to its origin.
module and_vec_source #(
    parameter int                LENGTH    = 10,
    parameter int                INIT      = 1000,
    parameter logic [LENGTH-1:0] TAPS      = 10'h240,
    parameter int                NUM_BEATS = 0,
    parameter int                CNT_W     = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic [1:0]        mode,
    input  logic              load,
    input  logic [LENGTH-1:0] seed,
    output logic [LENGTH-1:0] x,
    output logic              x_valid,
    input  logic              x_ready,
    output logic              wrap,
    output logic [CNT_W-1:0]  beats,
    output logic              done
);

    // FSM encoding
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    // Pattern modes
    localparam logic [1:0] M_UP   = 2'd0;
    localparam logic [1:0] M_DOWN = 2'd1;
    localparam logic [1:0] M_LFSR = 2'd2;
    localparam logic [1:0] M_WALK = 2'd3;

    localparam logic [LENGTH-1:0] INIT_X   = LENGTH'(INIT);
    localparam logic [LENGTH-1:0] X_ONE    = LENGTH'(1);
    localparam logic [LENGTH-1:0] X_ZERO   = '0;
    localparam logic [LENGTH-1:0] X_ONES   = '1;
    localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0]  CNT_MAX  = '1;
    localparam logic [CNT_W-1:0]  LIMIT    = CNT_W'(NUM_BEATS);
    localparam bit                LIMIT_EN = (NUM_BEATS != 0);

    // Next pattern value for a given mode.
    function automatic logic [LENGTH-1:0] next_pattern(
        input logic [1:0]        m,
        input logic [LENGTH-1:0] v
    );
        logic [LENGTH-1:0] r;
        case (m)
            M_UP:    r = v + X_ONE;
            M_DOWN:  r = v - X_ONE;
            M_LFSR:  r = {v[LENGTH-2:0], ^(v & TAPS)};
            default: r = {v[LENGTH-2:0], v[LENGTH-1]};
        endcase
        return r;
    endfunction

    // True when advancing v to nv returns the pattern to its origin.
    function automatic logic wrap_event(
        input logic [1:0]        m,
        input logic [LENGTH-1:0] v,
        input logic [LENGTH-1:0] nv,
        input logic [LENGTH-1:0] org
    );
        logic r;
        case (m)
            M_UP:    r = (v == X_ONES);
            M_DOWN:  r = (v == X_ZERO);
            M_LFSR:  r = (nv == org);
            default: r = v[LENGTH-1];
        endcase
        return r;
    endfunction

    // Seed as actually loaded: an all-zero seed would lock up the LFSR
    // and the walking-one, so those modes substitute 1.
    function automatic logic [LENGTH-1:0] seed_value(
        input logic [1:0]        m,
        input logic [LENGTH-1:0] s
    );
        logic [LENGTH-1:0] r;
        if ((s == X_ZERO) && ((m == M_LFSR) || (m == M_WALK)))
            r = X_ONE;
        else
            r = s;
        return r;
    endfunction

    // Saturating increment of the beat counter.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] b);
        logic [CNT_W-1:0] r;
        if (b == CNT_MAX)
            r = b;
        else
            r = b + CNT_ONE;
        return r;
    endfunction

    logic [1:0]        state;
    logic [LENGTH-1:0] origin;
    logic              fire;
    logic [LENGTH-1:0] x_adv;
    logic              wrap_adv;
    logic [LENGTH-1:0] seed_fix;
    logic [CNT_W-1:0]  beats_adv;
    logic              hit_limit;

    // Combinational next-value terms used by the registered update.
    always_comb begin
        fire      = x_valid & x_ready;
        x_adv     = next_pattern(mode, x);
        wrap_adv  = wrap_event(mode, x, x_adv, origin);
        seed_fix  = seed_value(mode, seed);
        beats_adv = sat_inc(beats);
        hit_limit = LIMIT_EN && (beats_adv == LIMIT);
    end

    // Handshake FSM, pattern register, origin, beat counter and wrap pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= S_IDLE;
            x       <= INIT_X;
            origin  <= INIT_X;
            x_valid <= 1'b0;
            wrap    <= 1'b0;
            beats   <= '0;
            done    <= 1'b0;
        end else if (load) begin
            // Load overrides any simultaneous fire: the fire is not counted.
            x      <= seed_fix;
            origin <= seed_fix;
            beats  <= '0;
            done   <= 1'b0;
            wrap   <= 1'b0;
            case (state)
                S_RUN: begin
                    state   <= S_RUN;
                    x_valid <= 1'b1;
                end
                S_IDLE: begin
                    state   <= en ? S_RUN : S_IDLE;
                    x_valid <= en;
                end
                default: begin
                    state   <= S_IDLE;
                    x_valid <= 1'b0;
                end
            endcase
        end else begin
            wrap <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (en && !done) begin
                        state   <= S_RUN;
                        x_valid <= 1'b1;
                    end
                end
                S_RUN: begin
                    // A presented word stays until it fires; only then can
                    // the FSM leave RUN.
                    if (fire) begin
                        x     <= x_adv;
                        beats <= beats_adv;
                        wrap  <= wrap_adv;
                        if (hit_limit) begin
                            state   <= S_DONE;
                            x_valid <= 1'b0;
                            done    <= 1'b1;
                        end else if (!en) begin
                            state   <= S_IDLE;
                            x_valid <= 1'b0;
                        end
                    end
                end
                default: begin
                    state   <= S_DONE;
                    x_valid <= 1'b0;
                    done    <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_and_vec_source.sv
// Directed testbench for and_vec_source: one unlimited instance and one
// instance with a five-beat limit, driven from shared inputs.
module tb_and_vec_source;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic [1:0]  mode;
    logic        load;
    logic [9:0]  seed;
    logic        x_ready;

    logic [9:0]  x,     x_l;
    logic        x_valid, xv_l;
    logic        wrap,  wrap_l;
    logic [15:0] beats, beats_l;
    logic        done,  done_l;

    int checks   = 0;
    int failures = 0;
    int wrap_cnt;
    int wrap_at;
    int zero_cnt;

    and_vec_source #(.LENGTH(10), .INIT(1000), .TAPS(10'h240), .NUM_BEATS(0), .CNT_W(16)) u_dut (
        .clk(clk), .rst(rst), .en(en), .mode(mode), .load(load), .seed(seed),
        .x(x), .x_valid(x_valid), .x_ready(x_ready), .wrap(wrap),
        .beats(beats), .done(done)
    );

    and_vec_source #(.LENGTH(10), .INIT(1000), .TAPS(10'h240), .NUM_BEATS(5), .CNT_W(16)) u_lim (
        .clk(clk), .rst(rst), .en(en), .mode(mode), .load(load), .seed(seed),
        .x(x_l), .x_valid(xv_l), .x_ready(x_ready), .wrap(wrap_l),
        .beats(beats_l), .done(done_l)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; en = 1'b0; mode = 2'd0; load = 1'b0; seed = '0; x_ready = 1'b0;

        // Reset state while rst is held and one cycle after release
        #12;
        chk("rst_x", 32'(x), 1000);
        chk("rst_valid", 32'(x_valid), 0);
        chk("rst_beats", 32'(beats), 0);
        chk("rst_wrap", 32'(wrap), 0);
        chk("rst_done", 32'(done), 0);
        rst = 1'b0;
        step();
        chk("rel_x", 32'(x), 1000);
        chk("rel_valid", 32'(x_valid), 0);
        chk("rel_beats", 32'(beats), 0);
        chk("rel_done", 32'(done), 0);

        // Up-count with backpressure: ready pattern 1,0,1,1
        en = 1'b1; mode = 2'd0; seed = 10'd1022; load = 1'b1;
        step();
        load = 1'b0;
        chk("up_load_x", 32'(x), 1022);
        chk("up_load_valid", 32'(x_valid), 1);
        x_ready = 1'b1;
        step();
        chk("up_f1_x", 32'(x), 1023);
        chk("up_f1_wrap", 32'(wrap), 0);
        x_ready = 1'b0;
        step();
        chk("up_stall_x", 32'(x), 1023);
        chk("up_stall_beats", 32'(beats), 1);
        chk("up_stall_valid", 32'(x_valid), 1);
        x_ready = 1'b1;
        step();
        chk("up_f2_x", 32'(x), 0);
        chk("up_f2_wrap", 32'(wrap), 1);
        step();
        chk("up_f3_x", 32'(x), 1);
        chk("up_f3_wrap", 32'(wrap), 0);
        chk("up_beats", 32'(beats), 3);

        // Beat limit of five in down-count mode
        x_ready = 1'b0; mode = 2'd1; seed = 10'd2; load = 1'b1;
        step();
        load = 1'b0;
        chk("lim_load_x", 32'(x_l), 2);
        chk("lim_load_beats", 32'(beats_l), 0);
        x_ready = 1'b1;
        step();
        chk("lim_f1_x", 32'(x_l), 1);
        step();
        chk("lim_f2_x", 32'(x_l), 0);
        chk("lim_f2_wrap", 32'(wrap_l), 0);
        step();
        chk("lim_f3_x", 32'(x_l), 1023);
        chk("lim_f3_wrap", 32'(wrap_l), 1);
        step();
        chk("lim_f4_x", 32'(x_l), 1022);
        chk("lim_f4_wrap", 32'(wrap_l), 0);
        chk("lim_f4_valid", 32'(xv_l), 1);
        chk("lim_f4_done", 32'(done_l), 0);
        step();
        chk("lim_f5_x", 32'(x_l), 1021);
        chk("lim_f5_valid", 32'(xv_l), 0);
        chk("lim_f5_done", 32'(done_l), 1);
        chk("lim_f5_beats", 32'(beats_l), 5);
        chk("unlim_f5_valid", 32'(x_valid), 1);
        step();
        chk("lim_hold_x", 32'(x_l), 1021);
        chk("lim_hold_valid", 32'(xv_l), 0);
        chk("lim_hold_done", 32'(done_l), 1);
        seed = 10'd7; load = 1'b1;
        step();
        load = 1'b0;
        chk("lim_reload_done", 32'(done_l), 0);
        chk("lim_reload_valid", 32'(xv_l), 0);
        chk("lim_reload_x", 32'(x_l), 7);
        chk("lim_reload_beats", 32'(beats_l), 0);
        x_ready = 1'b0;
        step();
        chk("lim_idle_to_run", 32'(xv_l), 1);

        // LFSR with zero seed: full period, single wrap on return to 1
        mode = 2'd2; seed = 10'd0; load = 1'b1;
        step();
        load = 1'b0;
        chk("lfsr_load_x", 32'(x), 1);
        x_ready = 1'b1;
        wrap_cnt = 0; wrap_at = 0; zero_cnt = 0;
        for (int i = 1; i <= 1023; i++) begin
            step();
            if (wrap === 1'b1) begin
                wrap_cnt++;
                wrap_at = i;
            end
            if (x === 10'd0) zero_cnt++;
        end
        x_ready = 1'b0;
        chk("lfsr_wrap_count", 32'(wrap_cnt), 1);
        chk("lfsr_wrap_at", 32'(wrap_at), 1023);
        chk("lfsr_zero_count", 32'(zero_cnt), 0);
        chk("lfsr_end_x", 32'(x), 1);
        chk("lfsr_beats", 32'(beats), 1023);

        // Walking-one, then load colliding with a fire
        mode = 2'd3; seed = 10'h200; load = 1'b1;
        step();
        load = 1'b0;
        chk("walk_load_x", 32'(x), 32'h200);
        x_ready = 1'b1;
        step();
        chk("walk_f1_x", 32'(x), 1);
        chk("walk_f1_wrap", 32'(wrap), 1);
        chk("walk_f1_beats", 32'(beats), 1);
        seed = 10'h005; load = 1'b1;
        step();
        load = 1'b0;
        chk("coll_x", 32'(x), 5);
        chk("coll_beats", 32'(beats), 0);
        chk("coll_wrap", 32'(wrap), 0);
        chk("coll_valid", 32'(x_valid), 1);

        // Mode change while stalled takes effect only on the next advance
        x_ready = 1'b0; mode = 2'd0;
        step();
        chk("modechg_hold_x", 32'(x), 5);
        x_ready = 1'b1;
        step();
        chk("modechg_adv_x", 32'(x), 6);
        x_ready = 1'b0;
        step();
        chk("stall_valid", 32'(x_valid), 1);

        // Asynchronous reset between edges while stalled
        #2;
        rst = 1'b1;
        #1;
        chk("arst_x", 32'(x), 1000);
        chk("arst_valid", 32'(x_valid), 0);
        chk("arst_beats", 32'(beats), 0);
        en = 1'b0;
        #2;
        rst = 1'b0;
        step();
        chk("arst_rel_valid", 32'(x_valid), 0);
        chk("arst_rel_x", 32'(x), 1000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
